// File: rtl/uart_tx_buffer_if.sv
// AXI4-Lite style channel bundle: the master drives requests, the slave drives responses.
// The slave view carries only the write channels; the UART-facing master also polls status.
interface uart_tx_buffer_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO between an MMU AXI-Lite write port and a UART Lite: bytes written to 0x4
// are queued, then drained one at a time after polling the UART status for TX space.
//
// state  | meaning
// S_IDLE | ready to take a paired AW+W write when the FIFO has room
// S_RESP | holding bvalid until the MMU takes the response
// D_IDLE | FIFO empty, no UART traffic
// D_AR   | status read address (0x8) offered
// D_R    | waiting for status data; bit 3 set means UART TX full, poll again
// D_W    | head byte offered on AW and W, each dropped on its own ready
// D_B    | waiting for the UART write response; the byte is popped on bvalid
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_buffer_if.slave  mmu,
    uart_tx_buffer_if.master uart
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {S_IDLE, S_RESP} s_state_t;
    typedef enum logic [2:0] {D_IDLE, D_AR, D_R, D_W, D_B} d_state_t;

    s_state_t s_state, s_state_nxt;
    d_state_t d_state, d_state_nxt;
    logic     aw_done, aw_done_nxt;
    logic     w_done, w_done_nxt;

    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head, tail;
    logic [DEPTH_LOG2:0]   count;
    logic                  full, empty;
    logic                  accept, push, pop;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);
    assign push  = accept && (mmu.awaddr == 4'h4);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_state <= S_IDLE;
        end else begin
            s_state <= s_state_nxt;
        end
    end

    always_comb begin
        s_state_nxt = s_state;
        accept      = 1'b0;
        case (s_state)
            S_IDLE: begin
                if (mmu.awvalid && mmu.wvalid && !full) begin
                    accept      = 1'b1;
                    s_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (mmu.bready) s_state_nxt = S_IDLE;
            end
            default: s_state_nxt = S_IDLE;
        endcase
    end

    assign mmu.awready = !rst && (s_state == S_IDLE) && !full;
    assign mmu.wready  = !rst && (s_state == S_IDLE) && !full;
    assign mmu.bvalid  = !rst && (s_state == S_RESP);
    assign mmu.bresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= D_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            d_state <= d_state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        d_state_nxt = d_state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        pop         = 1'b0;
        case (d_state)
            D_IDLE: if (!empty) d_state_nxt = D_AR;
            D_AR:   if (uart.arready) d_state_nxt = D_R;
            D_R: begin
                if (uart.rvalid) d_state_nxt = uart.rdata[3] ? D_AR : D_W;
            end
            D_W: begin
                if (uart.awready) aw_done_nxt = 1'b1;
                if (uart.wready)  w_done_nxt  = 1'b1;
                if ((aw_done || uart.awready) && (w_done || uart.wready)) begin
                    d_state_nxt = D_B;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            D_B: begin
                if (uart.bvalid) begin
                    pop         = 1'b1;
                    d_state_nxt = D_IDLE;
                end
            end
            default: d_state_nxt = D_IDLE;
        endcase
    end

    assign uart.araddr  = 4'h8;
    assign uart.arvalid = !rst && (d_state == D_AR);
    assign uart.rready  = !rst && (d_state == D_R);
    assign uart.awaddr  = 4'h4;
    assign uart.awvalid = !rst && (d_state == D_W) && !aw_done;
    assign uart.wvalid  = !rst && (d_state == D_W) && !w_done;
    assign uart.wdata   = {24'h0, fifo_mem[tail]};
    assign uart.bready  = !rst && (d_state == D_B);

    // Head byte stays stable through D_W because pops only happen in D_B.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) head <= head + PTR_ONE;
            if (pop)  tail <= tail + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[head] <= mmu.wdata[7:0];
    end

    logic unused_bits;
    assign unused_bits = ^{mmu.wdata[31:8], uart.rdata[31:4], uart.rdata[2:0], uart.bresp};

endmodule
